// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with frame start, selectable bit order,
// ready/valid output handshake and a sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for a start bit
// SHIFT | frame in progress, cnt bits received
module serial_word_rx #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_in,
  input  logic         s_valid,
  input  logic         start,
  input  logic         dir,
  input  logic         out_ready,
  output logic [n-1:0] D_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [n-1:0]  sh, sh_shift;
  logic [CW-1:0] cnt;
  logic          dir_q, dir_sel;
  logic          take_first, take_bit, done;

  // A start bit shifts under the newly presented dir, not the stored one.
  always_comb begin
    dir_sel  = (s_valid && start) ? dir : dir_q;
    sh_shift = dir_sel ? {s_in, sh[n-1:1]} : {sh[n-2:0], s_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_first = 1'b0;
    take_bit   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid && start) begin
          take_first = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (s_valid && start) begin
          take_first = 1'b1;
        end else if (s_valid) begin
          take_bit = 1'b1;
          if (cnt == CW'(n - 1)) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh        <= '0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      D_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (take_first) begin
        sh    <= sh_shift;
        cnt   <= CW'(1);
        dir_q <= dir;
      end else if (take_bit) begin
        sh  <= sh_shift;
        cnt <= done ? '0 : cnt + CW'(1);
      end

      // A completed word is dropped only if the held word is not leaving now.
      if (done) begin
        if (!out_valid || out_ready) begin
          D_out     <= sh_shift;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule
